// File: rtl/curr_avg_pkg.sv
`default_nettype none
// curr_avg_pkg -- shared FSM encoding and default parameters for the current-sense averager. Rev 1.0
package curr_avg_pkg;

   localparam int DEF_DATA_W      = 12;
   localparam int DEF_LOG2_DEPTH  = 4;
   localparam int DEF_SMPL_PERIOD = 1000;
   localparam int DEF_TIMEOUT     = 64;
   localparam int SUM_W           = DEF_DATA_W + DEF_LOG2_DEPTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT   = 2'd2,
      UPDATE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/curr_avg_avg_accum.sv
`default_nettype none
// avg_accum -- 2^LOG2_DEPTH-entry circular sample buffer with running sum and fill flag. Rev 1.0
module avg_accum
   import curr_avg_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] avg,
   output logic              filled
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int ACC_W = DATA_W + LOG2_DEPTH;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wp;
   logic [ACC_W-1:0]      sum;
   logic [LOG2_DEPTH:0]   cnt;

   // Oldest sample leaves the sum as the new one enters; the top cnt bit saturates as the fill flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wp  <= '0;
         sum <= '0;
         cnt <= '0;
      end else if (wr_en) begin
         mem[wp] <= wr_data;
         wp      <= wp + 1'b1;
         sum     <= sum - ACC_W'(mem[wp]) + ACC_W'(wr_data);
         if (!cnt[LOG2_DEPTH]) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign avg    = sum[ACC_W-1:LOG2_DEPTH];
   assign filled = cnt[LOG2_DEPTH];

endmodule
`default_nettype wire

// File: rtl/curr_avg.sv
`default_nettype none
// curr_avg -- paces ADC conversions, handshakes each one and presents the boxcar-averaged current. Rev 1.0
module curr_avg
   import curr_avg_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int LOG2_DEPTH  = DEF_LOG2_DEPTH,
   parameter int SMPL_PERIOD = DEF_SMPL_PERIOD,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   output logic              conv_req,
   input  logic              conv_done,
   input  logic [DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0] avg_curr,
   output logic              avg_vld,
   output logic              filled,
   output logic              timeout_err
);

   localparam int PCNT_W = $clog2(SMPL_PERIOD);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SMPL_PERIOD - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   state_t              state;
   state_t              state_nxt;
   logic [PCNT_W-1:0]   pcnt;
   logic [TCNT_W-1:0]   tcnt;
   logic [DATA_W-1:0]   smpl;
   logic                tick;
   logic                expire;
   logic                wr_en;

   assign tick   = (pcnt == PCNT_LAST);
   assign expire = (tcnt == TCNT_LAST);

   always_ff @(posedge clk) begin
      if (rst || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A tick outside IDLE is simply lost; conv_done beats a coincident timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT: begin
            if (conv_done) begin
               state_nxt = UPDATE;
            end else if (expire) begin
               state_nxt = IDLE;
            end
         end
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      conv_req = (state == REQ);
      wr_en    = (state == UPDATE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt        <= '0;
         smpl        <= '0;
         avg_vld     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         avg_vld <= (state == UPDATE);
         if (state == REQ) begin
            tcnt <= '0;
         end else if (state == WAIT) begin
            tcnt <= tcnt + 1'b1;
            if (conv_done) begin
               smpl <= adc_data;
            end else if (expire) begin
               timeout_err <= 1'b1;
            end
         end
      end
   end

   avg_accum #(
      .DATA_W     (DATA_W),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_avg_accum (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (smpl),
      .avg     (avg_curr),
      .filled  (filled)
   );

endmodule
`default_nettype wire

// File: tb/tb_curr_avg.sv
`default_nettype none
// tb_curr_avg -- directed vectors with a queued scoreboard checked on every avg_vld. Rev 1.0
module tb_curr_avg;

   localparam int DATA_W  = 12;
   localparam int SP      = 100;
   localparam int TIMEOUT = 64;

   typedef struct {
      logic [DATA_W-1:0] avg;
      logic              fil;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              conv_req;
   logic              conv_done = 1'b0;
   logic [DATA_W-1:0] adc_data = '0;
   logic [DATA_W-1:0] avg_curr;
   logic              avg_vld;
   logic              filled;
   logic              timeout_err;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   last_req = -1;

   always #5 clk = ~clk;

   curr_avg #(
      .DATA_W      (DATA_W),
      .LOG2_DEPTH  (4),
      .SMPL_PERIOD (SP),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .conv_req    (conv_req),
      .conv_done   (conv_done),
      .adc_data    (adc_data),
      .avg_curr    (avg_curr),
      .avg_vld     (avg_vld),
      .filled      (filled),
      .timeout_err (timeout_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every avg_vld pops one expected result.
   always @(negedge clk) begin
      if (!rst && avg_vld) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_avg_vld: got avg_curr=0x%0h, expected no pulse (t=%0t)", avg_curr, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("avg_curr", 32'(avg_curr), 32'(mon_e.avg));
            check("filled", 32'(filled), 32'(mon_e.fil));
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         last_req = -1;
      end else if (conv_req) begin
         if (last_req >= 0) check("req_spacing", 32'(cyc - last_req), 32'(SP));
         last_req = cyc;
      end
   end

   // Returns at the negedge of the conv_req cycle, or flags a failure after a bounded wait.
   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < SP + 10; i++) begin
         @(negedge clk);
         if (conv_req) begin
            ok = 1'b1;
            return;
         end
      end
      n_cmp++;
      n_fail++;
      $display("FAIL conv_req_wait: got no conv_req within %0d cycles, expected one", SP + 10);
   endtask

   task automatic drive_done(input int dly, input logic [DATA_W-1:0] d);
      repeat (dly) @(negedge clk);
      #1;
      conv_done = 1'b1;
      adc_data  = d;
      @(negedge clk);
      #1;
      conv_done = 1'b0;
   endtask

   task automatic push(input logic [DATA_W-1:0] a, input logic f);
      exp_t e;
      e.avg = a;
      e.fil = f;
      exp_q.push_back(e);
   endtask

   initial begin
      bit ok;
      int n;

      // Reset and idle
      repeat (3) @(negedge clk);
      check("rst_conv_req", 32'(conv_req), 0);
      check("rst_avg_curr", 32'(avg_curr), 0);
      check("rst_avg_vld", 32'(avg_vld), 0);
      check("rst_filled", 32'(filled), 0);
      check("rst_timeout_err", 32'(timeout_err), 0);
      #1 rst = 1'b0;
      n = 0;
      for (int i = 1; i <= SP + 5; i++) begin
         @(negedge clk);
         if (conv_req) begin
            n = i;
            break;
         end
      end
      check("first_req_latency", 32'(n), 32'(SP));

      // Step and ramp: 0x800 samples, average climbs by 0x080 each update
      for (int k = 1; k <= 18; k++) begin
         if (k > 1) wait_req(ok);
         push((k >= 16) ? 12'h800 : DATA_W'(k * 'h80), k >= 16);
         drive_done(5, 12'h800);
      end

      // Timeout: no done; error rises TIMEOUT+1 cycles after conv_req
      wait_req(ok);
      repeat (TIMEOUT) @(negedge clk);
      check("timeout_err_early", 32'(timeout_err), 0);
      @(negedge clk);
      check("timeout_err_set", 32'(timeout_err), 1);
      check("avg_hold_timeout", 32'(avg_curr), 32'h800);

      // Window wrap: zeros evict 0x800 samples one at a time
      for (int k = 1; k <= 16; k++) begin
         wait_req(ok);
         push(DATA_W'('h800 - k * 'h80), 1'b1);
         drive_done(5, 12'h000);
      end
      repeat (5) @(negedge clk);
      check("timeout_err_sticky", 32'(timeout_err), 1);

      // Reset mid-WAIT: a later done must be ignored
      wait_req(ok);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      drive_done(1, 12'hABC);
      repeat (5) @(negedge clk);
      check("midwait_avg", 32'(avg_curr), 0);
      check("midwait_filled", 32'(filled), 0);
      check("midwait_err_cleared", 32'(timeout_err), 0);

      // Stray done while IDLE
      drive_done(10, 12'h123);
      repeat (5) @(negedge clk);
      check("stray_avg", 32'(avg_curr), 0);

      // Done on the timeout-expiry cycle: sample taken, no error
      wait_req(ok);
      push(12'h0FF, 1'b0);
      drive_done(TIMEOUT, 12'hFFF);
      repeat (5) @(negedge clk);
      check("simul_timeout_err", 32'(timeout_err), 0);
      check("simul_avg", 32'(avg_curr), 32'h0FF);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/curr_avg.md
# curr_avg

Upstream sense stage for the current-loop PID controller. It paces ADC conversions with a programmable sample period and handshakes each conversion. It keeps a 16-deep circular buffer of current samples with a running sum, and presents the boxcar average as `avg_curr`, the PID's feedback input. It also flags conversions that never complete.

## Interface
- `DATA_W`, 12, width of ADC sample and of `avg_curr`
- `LOG2_DEPTH`, 4, log2 of averaging window (16 samples)
- `SMPL_PERIOD`, 1000, clocks between conversion requests (≥ 8)
- `TIMEOUT`, 64, clocks allowed from `conv_req` to `conv_done`

- `clk` in 1: the single clock; all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `conv_req` out 1: one-cycle conversion start strobe to ADC interface
- `conv_done` in 1: one-cycle strobe, `adc_data` valid this cycle
- `adc_data` in DATA_W: unsigned current sample
- `avg_curr` out DATA_W: windowed average, to PID
- `avg_vld` out 1: one-cycle pulse when `avg_curr` takes a new value
- `filled` out 1: high once DEPTH samples have been accumulated since reset
- `timeout_err` out 1: sticky, set on conversion timeout, cleared only by `rst`

## Operation
- The period counter `pcnt` runs freely from 0 to SMPL_PERIOD-1 and wraps. The wrap cycle is a `tick`.
- FSM states:
  - IDLE: on `tick`, go to REQ.
  - REQ: drive `conv_req`=1 for this one cycle, clear the timeout counter, then go to WAIT.
  - WAIT: if `conv_done`, capture `adc_data` into `smpl` and go to UPDATE. Otherwise, when the timeout counter reaches TIMEOUT-1, set `timeout_err` and go to IDLE without updating.
  - UPDATE: perform the buffer update below, set `avg_vld` (registered), then go to IDLE.
- A `tick` that arrives while the FSM is not in IDLE is dropped. There is no queuing.
- `conv_done` is ignored in every state except WAIT.
- If `conv_done` and timeout expiry occur in the same cycle, `conv_done` wins: no error, sample taken.
- Buffer update in UPDATE:
  - `sum <= sum - buf[wp] + smpl`
  - `buf[wp] <= smpl`
  - `wp <= wp + 1`, a LOG2_DEPTH-bit pointer that wraps modulo DEPTH.
- `sum` is DATA_W+LOG2_DEPTH bits wide and unsigned. It never overflows because it is bounded by DEPTH·(2^DATA_W−1).
- `avg_curr = sum[DATA_W+LOG2_DEPTH-1 : LOG2_DEPTH]`, i.e. a truncating divide driven directly from the `sum` register.
- The buffer is zeroed at reset, so the average ramps up from 0 before the window fills.
- A saturating sample counter sets `filled` on the DEPTH-th update. `filled` stays high until reset.

## Timing
- Reset values:
  - state IDLE, `pcnt`=0, `wp`=0, `sum`=0, all `buf` entries 0
  - `conv_req`=0, `avg_curr`=0, `avg_vld`=0, `filled`=0, `timeout_err`=0
- `rst` asserted in any state, including mid-WAIT, aborts the conversion. A `conv_done` arriving afterwards is ignored.
- First `tick` occurs SMPL_PERIOD-1 cycles after reset deasserts. `conv_req` follows 1 cycle later (REQ state).
- Latency: `conv_done` in cycle N leads to UPDATE in N+1. `avg_curr` holds the new value and `avg_vld`=1 in N+2.
- `avg_curr` is stable between `avg_vld` pulses, including after a timeout.
- Timeout: with no `conv_done`, `timeout_err` rises TIMEOUT+1 cycles after the `conv_req` cycle.
- Maximum throughput is one sample per SMPL_PERIOD.

## Structure
- Package `curr_avg_pkg`:
  - `state_t` enum {IDLE, REQ, WAIT, UPDATE}
  - default parameter constants
  - `SUM_W = DATA_W+LOG2_DEPTH`
- Sub-module `avg_accum`: circular buffer, write pointer, running sum, fill counter. Ports are `clk`, `rst`, `wr_en`, `wr_data`, `avg`, `filled`.
- Top level: period counter, timeout counter, FSM, output registers.

## Test plan
- Reset and idle: hold `rst` for 3 cycles. Expect all outputs 0, and `conv_req` pulse spacing exactly SMPL_PERIOD.
- Step and ramp: answer every `conv_req` with `conv_done` and 0x800 after 5 cycles. Expect `avg_curr` = 0x080, 0x100, … 0x800 on successive `avg_vld`, `filled`=1 at the 16th, then a constant 0x800.
- Window wrap: after fill, feed 16 samples of 0x000. Expect `avg_curr` to step down 0x780 … 0x000, showing the oldest sample evicted each time.
- Timeout: never assert `conv_done`. Expect `timeout_err`=1 TIMEOUT+1 cycles after `conv_req`, `avg_vld` never pulsing, and `avg_curr` holding. The next period still issues `conv_req`.
- Stray and simultaneous done: a `conv_done` in IDLE is ignored with no `avg_vld`. A `conv_done` on the timeout-expiry cycle with 0xFFF gives no error, and `avg_curr` rises by 0x0FF from 0.
- Reset mid-WAIT: assert `rst` after `conv_req` and before done, then deliver `conv_done`. Expect the done ignored, `avg_curr`=0, `filled`=0.
